// File: rtl/master_tx.sv
// master_tx: transmit end of the master-to-slave byte link.
// Bytes from the local write port are buffered in a circular FIFO. The FSM requests the slave
// (REQ), then streams the FIFO head on data_out with valid until each ready completes a transfer.
// Optional feature: define MASTER_TX_TIMEOUT_EN to abort a stalled XFER after TIMEOUT cycles
// (timeout_err pulses, head byte kept, request restarts from IDLE).
module master_tx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  input  logic        ready,
  output logic        data_en,
  output logic        valid,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic [15:0] tx_count,
  output logic        timeout_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     tx_count_q, tx_count_d;
  logic            push, pop, abort;

  // Status and link outputs decode registered state only.
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    data_en  = (state_q == StReq) || (state_q == StXfer);
    valid    = (state_q == StXfer) && !empty;
    data_out = (state_q == StXfer) ? mem_q[rd_ptr_q] : 8'h00;
    busy     = (state_q != StIdle);
    tx_count = tx_count_q;
    push     = wr_en && !full;
    pop      = valid && ready;
  end

  // FIFO pointer, occupancy and transfer-count next state.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    tx_count_d = tx_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      tx_count_d = tx_count_q + 16'd1;
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Next-state logic: leave XFER when the FIFO runs dry or the stall limit aborts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!empty) state_d = StReq;
      StReq:  state_d = StXfer;
      StXfer: begin
        if (abort || empty || (pop && !push && count_q == CntW'(1))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointers, occupancy and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_count_q <= tx_count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef MASTER_TX_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;
  logic       timeout_q;

  // Count stalled XFER cycles; any transfer or exit from XFER clears the count.
  always_comb begin
    stall_d = '0;
    abort   = 1'b0;
    if (state_q == StXfer && valid && !ready) begin
      if (stall_q == 8'(TIMEOUT - 1)) begin
        abort = 1'b1;
      end else begin
        stall_d = stall_q + 8'd1;
      end
    end
  end

  // Stall counter and the one-cycle abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= abort;
    end
  end

  assign timeout_err = timeout_q;
`else
  // Without the timeout logic the stall limit is inert.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_master_tx.sv
// tb_master_tx: directed checks of latency, burst, reset and counter wrap, plus a randomized
// run against a queue-based model of the byte stream. Honours MASTER_TX_TIMEOUT_EN.
module tb_master_tx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk, rst, wr_en, ready, stall, ready_q;
  logic [7:0]  wr_data, data_out;
  logic        full, empty, data_en, valid, busy, timeout_err;
  logic [15:0] tx_count;

  int          ncomp = 0;
  int          nfail = 0;
  int          bad, cyc, xfers, pushes;
  logic        was_full;
  logic [15:0] exp_cnt;
  logic [7:0]  q[$];

  master_tx #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .ready      (ready),
    .data_en    (data_en),
    .valid      (valid),
    .data_out   (data_out),
    .busy       (busy),
    .tx_count   (tx_count),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: ready is data_en registered; stall lets the bench hold it off.
  always @(posedge clk) ready_q <= rst ? 1'b0 : data_en;
  assign ready = ready_q & ~stall;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at a falling edge just after one reset edge, inputs idle.
  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chkb("rst_full", full, 1'b0);
    chkb("rst_empty", empty, 1'b1);
    chkb("rst_data_en", data_en, 1'b0);
    chkb("rst_valid", valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_timeout_err", timeout_err, 1'b0);
    chkd("rst_data_out", data_out, 8'h00);
    chkw("rst_tx_count", tx_count, 16'h0000);

    // Single byte latency
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    chkb("t1_empty_c1", empty, 1'b0);
    chkb("t1_data_en_c1", data_en, 1'b0);
    @(negedge clk);
    chkb("t1_data_en_c2", data_en, 1'b1);
    chkb("t1_valid_c2", valid, 1'b0);
    @(negedge clk);
    chkb("t1_valid_c3", valid, 1'b1);
    chkb("t1_ready_c3", ready, 1'b1);
    chkd("t1_data_c3", data_out, 8'hA5);
    @(negedge clk);
    chkw("t1_count_c4", tx_count, 16'd1);
    chkb("t1_busy_c4", busy, 1'b0);
    chkb("t1_empty_c4", empty, 1'b1);
    chkb("t1_data_en_c4", data_en, 1'b0);
    chkb("t1_ready_lag_c4", ready, 1'b1);
    chkb("t1_valid_c4", valid, 1'b0);

    // Fill to full with the slave held off, drop a fifth write, then burst
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      @(negedge clk);
    end
    chkb("t2_full", full, 1'b1);
    wr_data = 8'hFF;
    @(negedge clk); wr_en = 1'b0;
    chkb("t2_full_after_drop", full, 1'b1);
    stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chkb("t2_xfer", valid & ready, 1'b1);
      chkd("t2_byte", data_out, 8'(i + 1));
      @(negedge clk);
    end
    chkw("t2_count", tx_count, 16'd4);
    chkb("t2_empty", empty, 1'b1);
    chkb("t2_valid_end", valid, 1'b0);

    // Push during the pop of the last byte keeps XFER going
    do_reset();
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chkb("t3_xfer", valid & ready, 1'b1);
    wr_en = 1'b1; wr_data = 8'hC3;
    @(negedge clk); wr_en = 1'b0;
    chkb("t3_stay_valid", valid, 1'b1);
    chkb("t3_ready", ready, 1'b1);
    chkd("t3_next_byte", data_out, 8'hC3);
    chkw("t3_count1", tx_count, 16'd1);
    @(negedge clk);
    chkw("t3_count2", tx_count, 16'd2);
    chkb("t3_idle", busy, 1'b0);

    // Stalled slave
    do_reset();
    stall = 1'b1;
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef MASTER_TX_TIMEOUT_EN
    cyc = 3;
    while (!timeout_err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chkw("t4_timeout_cycle", 16'(cyc), 16'd19);
    chkb("t4_timeout_idle", busy, 1'b0);
    @(negedge clk);
    chkb("t4_rerequest", data_en, 1'b1);
    chkb("t4_rerequest_valid", valid, 1'b0);
    chkb("t4_pulse_width", timeout_err, 1'b0);
`else
    bad = 0;
    repeat (30) begin
      if (!valid || timeout_err) bad++;
      @(negedge clk);
    end
    chkw("t4_valid_held", 16'(bad), 16'd0);
`endif
    stall = 1'b0;
    #1;
    cyc = 0;
    while (!(valid && ready) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chkb("t4_xfer_found", valid & ready, 1'b1);
    chkd("t4_byte", data_out, 8'h5A);
    @(negedge clk);
    chkw("t4_count", tx_count, 16'd1);

    // Reset mid-burst discards buffered bytes
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    wr_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    chkb("t5_data_en", data_en, 1'b0);
    chkb("t5_valid", valid, 1'b0);
    chkb("t5_empty", empty, 1'b1);
    chkw("t5_count", tx_count, 16'd0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid || !empty || busy) bad++;
    end
    chkw("t5_quiet", 16'(bad), 16'd0);
    chkw("t5_count_after", tx_count, 16'd0);

    // Randomized traffic against a queue model of the byte stream
    do_reset();
    q.delete();
    exp_cnt = 16'd0;
    repeat (3000) begin
      chkb("r_full", full, q.size() == DEPTH);
      chkb("r_empty", empty, q.size() == 0);
      chkw("r_count", tx_count, exp_cnt);
      chkb("r_valid_without_data", valid && q.size() == 0, 1'b0);
      if (!busy) chkd("r_idle_data_out", data_out, 8'h00);
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom);
      stall   = ($urandom_range(0, 3) == 0);
      #1;
      was_full = (q.size() == DEPTH);
      if (valid && ready && q.size() > 0) begin
        chkd("r_byte", data_out, q[0]);
        void'(q.pop_front());
        exp_cnt++;
      end
      if (wr_en && !was_full) q.push_back(wr_data);
      @(negedge clk);
    end
    wr_en = 1'b0; stall = 1'b0;
    #1;
    cyc = 0;
    while (q.size() > 0 && cyc < 60) begin
      if (valid && ready) begin
        chkd("r_drain_byte", data_out, q[0]);
        void'(q.pop_front());
        exp_cnt++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chkb("r_drained", q.size() == 0, 1'b1);
    chkw("r_count_final", tx_count, exp_cnt);
    chkb("r_empty_final", empty, 1'b1);

    // tx_count wraps from 0xFFFF to 0
    do_reset();
    xfers = 0; pushes = 0; cyc = 0;
    while (xfers < 65536 && cyc < 70000) begin
      if (xfers == 65535) chkw("w_count_ffff", tx_count, 16'hFFFF);
      wr_en   = (pushes < 65536);
      wr_data = 8'(pushes);
      if (wr_en && !full) pushes++;
      if (valid && ready) xfers++;
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    chkb("w_all_sent", xfers == 65536, 1'b1);
    chkw("w_wrapped", tx_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
